// File: rtl/rx_sample_framer.sv
// rtl/rx_sample_framer.sv - RX sample FIFO and framer: header + N samples, overrun error frame
module rx_sample_framer #(
    parameter int BASE    = 176,
    parameter int FIFO_AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] sample,
    input  logic        strobe,
    output logic        run,
    output logic [35:0] data_o,
    output logic        src_rdy_o,
    input  logic        dst_rdy_i,
    output logic        overrun,
    output logic [31:0] debug
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_BODY = 3'd2,
        S_ERR  = 3'd3
    } state_t;

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [7:0] ADDR_LEN = 8'(BASE);
    localparam logic [7:0] ADDR_CTL = 8'(BASE + 1);

    state_t               state_q, state_d;
    logic [15:0]          len_q, len_d;
    logic                 enable_q, enable_d;
    logic                 run_q, run_d;
    logic                 overrun_q, overrun_d;
    logic                 err_pend_q, err_pend_d;
    logic [15:0]          acc_q, acc_d;
    logic [11:0]          seq_q, seq_d;
    logic [15:0]          flen_q, flen_d;
    logic [15:0]          rem_q, rem_d;
    logic                 sent_q, sent_d;
    logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]     cnt_q, cnt_d;
    logic [31:0]          mem_q [DEPTH];

    logic        wr_len, wr_ctl, run_start;
    logic [15:0] len_eff;
    logic        fifo_full, fifo_empty, fifo_rd, fifo_wr, wr_req, ovr_evt;
    logic        body_eof, err_clr;
    logic        unused_ok;

    assign unused_ok  = &{1'b0, set_data[31:16]};
    assign wr_len     = set_stb && (set_addr == ADDR_LEN);
    assign wr_ctl     = set_stb && (set_addr == ADDR_CTL);
    assign run_start  = wr_ctl && set_data[0];
    assign len_eff    = (len_q == 16'd0) ? 16'd1 : len_q;
    assign fifo_full  = (cnt_q == (FIFO_AW+1)'(DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign fifo_rd    = (state_q == S_BODY) && !fifo_empty && dst_rdy_i;
    assign wr_req     = strobe && run_q;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign fifo_wr    = wr_req && (!fifo_full || fifo_rd);
    assign ovr_evt    = wr_req && fifo_full && !fifo_rd;
    assign body_eof   = (rem_q == 16'd1) || (err_pend_q && cnt_q == (FIFO_AW+1)'(1));

    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        flen_d    = flen_q;
        rem_d     = rem_q;
        sent_d    = sent_q;
        err_clr   = 1'b0;
        src_rdy_o = 1'b0;
        data_o    = '0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_HDR;
                    flen_d  = len_eff;
                end
            end
            S_HDR: begin
                src_rdy_o = 1'b1;
                data_o    = {2'b00, 1'b0, 1'b1, seq_q, 4'h0, flen_q};
                if (dst_rdy_i) begin
                    seq_d   = seq_q + 12'd1;
                    rem_d   = flen_q;
                    sent_d  = 1'b0;
                    state_d = S_BODY;
                end
            end
            S_BODY: begin
                if (!fifo_empty) begin
                    src_rdy_o = 1'b1;
                    data_o    = {2'b00, body_eof, 1'b0, mem_q[rd_ptr_q]};
                    if (fifo_rd) begin
                        rem_d  = rem_q - 16'd1;
                        sent_d = 1'b1;
                        if (body_eof) state_d = err_pend_q ? S_ERR : S_IDLE;
                    end
                end else if (err_pend_q && !sent_q) begin
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                src_rdy_o = 1'b1;
                data_o    = {2'b00, 1'b1, 1'b1, seq_q, 4'h1, 16'h0000};
                if (dst_rdy_i) begin
                    seq_d   = seq_q + 12'd1;
                    err_clr = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        len_d      = wr_len ? set_data[15:0] : len_q;
        enable_d   = enable_q;
        overrun_d  = overrun_q;
        err_pend_d = err_pend_q;
        acc_d      = acc_q;
        if (wr_ctl) begin
            enable_d = set_data[0];
            if (set_data[0]) overrun_d = 1'b0;
        end
        if (err_clr) err_pend_d = 1'b0;
        if (fifo_wr)
            acc_d = ({1'b0, acc_q} + 17'd1 >= {1'b0, len_eff}) ? 16'd0 : acc_q + 16'd1;
        if (run_start && !run_q) acc_d = 16'd0;
        if (ovr_evt) begin
            enable_d   = 1'b0;
            overrun_d  = 1'b1;
            err_pend_d = 1'b1;
            acc_d      = 16'd0;
        end
        // With enable cleared, keep running until the accept counter closes the frame.
        run_d = !ovr_evt && (run_start || (run_q && (enable_d || acc_d != 16'd0)));
        cnt_d = cnt_q;
        if (fifo_wr && !fifo_rd)      cnt_d = cnt_q + (FIFO_AW+1)'(1);
        else if (!fifo_wr && fifo_rd) cnt_d = cnt_q - (FIFO_AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= 16'd1;
            enable_q   <= 1'b0;
            run_q      <= 1'b0;
            overrun_q  <= 1'b0;
            err_pend_q <= 1'b0;
            acc_q      <= '0;
            seq_q      <= '0;
            flen_q     <= 16'd1;
            rem_q      <= '0;
            sent_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            enable_q   <= enable_d;
            run_q      <= run_d;
            overrun_q  <= overrun_d;
            err_pend_q <= err_pend_d;
            acc_q      <= acc_d;
            seq_q      <= seq_d;
            flen_q     <= flen_d;
            rem_q      <= rem_d;
            sent_q     <= sent_d;
            cnt_q      <= cnt_d;
            if (fifo_wr) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (fifo_rd) rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) mem_q[wr_ptr_q] <= sample;
    end

    assign run     = run_q;
    assign overrun = overrun_q;
    assign debug   = {state_q, cnt_q, seq_q, run_q, overrun_q, {(14-FIFO_AW){1'b0}}};
endmodule

// File: tb/tb_rx_sample_framer.sv
// tb/tb_rx_sample_framer.sv - randomized self-checking bench for rx_sample_framer
module tb_rx_sample_framer;
    localparam logic [7:0] A_LEN = 8'd176;
    localparam logic [7:0] A_CTL = 8'd177;

    logic        clk = 1'b0;
    logic        rst, set_stb, strobe, run, src_rdy_o, dst_rdy_i, overrun;
    logic [7:0]  set_addr;
    logic [31:0] set_data, sample, debug;
    logic [35:0] data_o;

    int n_total = 0;
    int n_pass  = 0;
    int exp_seq = 0;
    int stall_viol = 0;
    logic        prev_stall = 1'b0;
    logic [35:0] prev_data = '0;
    logic [35:0] got_q [$];
    logic [35:0] exp_q [$];
    logic [31:0] samp_q [$];

    always #5 clk = ~clk;

    rx_sample_framer #(.BASE(176), .FIFO_AW(4)) dut (
        .clk(clk), .rst(rst), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .sample(sample), .strobe(strobe), .run(run), .data_o(data_o), .src_rdy_o(src_rdy_o),
        .dst_rdy_i(dst_rdy_i), .overrun(overrun), .debug(debug)
    );

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!src_rdy_o || data_o !== prev_data)) stall_viol++;
            if (src_rdy_o && dst_rdy_i) got_q.push_back(data_o);
            prev_stall = src_rdy_o && !dst_rdy_i;
            prev_data  = data_o;
        end
    end

    function automatic logic [35:0] hdr_w(input int s, input int l);
        return {2'b00, 2'b01, 12'(s), 4'h0, 16'(l)};
    endfunction
    function automatic logic [35:0] body_w(input logic [31:0] d, input bit eof);
        return {2'b00, eof, 1'b0, d};
    endfunction
    function automatic logic [35:0] err_w(input int s);
        return {2'b00, 2'b11, 12'(s), 4'h1, 16'h0000};
    endfunction

    // Reference framing: chop the accepted sample list into frames of L (0 means 1).
    task automatic model_frames(input int len);
        int eff = (len == 0) ? 1 : len;
        int idx = 0;
        while (samp_q.size() - idx >= eff) begin
            exp_q.push_back(hdr_w(exp_seq, eff));
            exp_seq = (exp_seq + 1) % 4096;
            for (int k = 0; k < eff; k++) exp_q.push_back(body_w(samp_q[idx+k], k == eff-1));
            idx += eff;
        end
    endtask

    task automatic tick; @(posedge clk); #1; endtask

    task automatic do_reset;
        rst = 1'b1; strobe = 1'b0; set_stb = 1'b0; dst_rdy_i = 1'b1;
        set_addr = '0; set_data = '0; sample = '0;
        tick; tick;
        rst = 1'b0;
        exp_seq = 0; stall_viol = 0;
        got_q.delete(); exp_q.delete(); samp_q.delete();
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
        set_stb = 1'b1; set_addr = a; set_data = d;
        tick;
        set_stb = 1'b0;
    endtask

    task automatic put(input logic [31:0] d);
        sample = d; strobe = 1'b1;
        tick;
        strobe = 1'b0;
    endtask

    task automatic wait_out(input int n);
        for (int c = 0; c < 4000 && got_q.size() < n; c++) tick;
        repeat (20) tick;
    endtask

    task automatic test_reset;
        do_reset;
        n_total++; if (run !== 1'b0) $display("FAIL reset_run: got %b want 0", run); else n_pass++;
        n_total++; if (src_rdy_o !== 1'b0) $display("FAIL reset_src_rdy: got %b want 0", src_rdy_o); else n_pass++;
        n_total++; if (data_o !== 36'h0) $display("FAIL reset_data: got %h want 0", data_o); else n_pass++;
        n_total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else n_pass++;
        n_total++; if (debug[28:0] !== 29'h0) $display("FAIL reset_debug: got %h want 0", debug[28:0]); else n_pass++;
        wr_reg(A_CTL, 32'h1);
        n_total++; if (run !== 1'b1) $display("FAIL enable_run: got %b want 1", run); else n_pass++;
    endtask

    task automatic test_basic;
        logic [31:0] d;
        do_reset;
        wr_reg(A_LEN, 32'd4);
        wr_reg(A_CTL, 32'h1);
        for (int i = 0; i < 8; i++) begin
            d = 32'h00010002 + 32'(i) * 32'h00020002;
            put(d);
            samp_q.push_back(d);
            if (i == 0) begin
                n_total++; if (src_rdy_o !== 1'b0) $display("FAIL basic_early_hdr: got %b want 0", src_rdy_o); else n_pass++;
            end
            tick;
            if (i == 0) begin
                n_total++; if (src_rdy_o !== 1'b1 || data_o !== 36'h100000004)
                    $display("FAIL basic_hdr_latency: got %b/%h want 1/100000004", src_rdy_o, data_o); else n_pass++;
            end
        end
        model_frames(4);
        wait_out(exp_q.size());
        n_total++; if (got_q.size() !== exp_q.size()) $display("FAIL basic_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL basic_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_run_stop;
        logic [31:0] d;
        do_reset;
        wr_reg(A_LEN, 32'd3);
        wr_reg(A_CTL, 32'h1);
        for (int i = 0; i < 4; i++) begin d = $urandom; put(d); samp_q.push_back(d); end
        wr_reg(A_CTL, 32'h0);
        n_total++; if (run !== 1'b1) $display("FAIL stop_run_mid: got %b want 1", run); else n_pass++;
        d = $urandom; put(d); samp_q.push_back(d);
        n_total++; if (run !== 1'b1) $display("FAIL stop_run_5: got %b want 1", run); else n_pass++;
        d = $urandom; put(d); samp_q.push_back(d);
        n_total++; if (run !== 1'b0) $display("FAIL stop_run_6: got %b want 0", run); else n_pass++;
        for (int i = 0; i < 3; i++) put($urandom);
        model_frames(3);
        wait_out(exp_q.size());
        n_total++; if (got_q.size() !== exp_q.size()) $display("FAIL stop_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL stop_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_overrun;
        logic [31:0] d;
        do_reset;
        wr_reg(A_LEN, 32'd20);
        wr_reg(A_CTL, 32'h1);
        dst_rdy_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            d = $urandom; put(d);
            if (i < 16) samp_q.push_back(d);
            if (i == 15) begin
                n_total++; if (overrun !== 1'b0 || run !== 1'b1)
                    $display("FAIL ovr_before: got ovr=%b run=%b want 0/1", overrun, run); else n_pass++;
            end
            if (i == 16) begin
                n_total++; if (overrun !== 1'b1 || run !== 1'b0)
                    $display("FAIL ovr_set: got ovr=%b run=%b want 1/0", overrun, run); else n_pass++;
            end
        end
        dst_rdy_i = 1'b1;
        exp_q.push_back(hdr_w(0, 20));
        for (int k = 0; k < 16; k++) exp_q.push_back(body_w(samp_q[k], k == 15));
        exp_q.push_back(err_w(1));
        wait_out(exp_q.size());
        n_total++; if (got_q.size() !== exp_q.size()) $display("FAIL ovr_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL ovr_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_total++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", overrun); else n_pass++;
        n_total++; if (debug[28:24] !== 5'd0) $display("FAIL ovr_drained: got %0d want 0", debug[28:24]); else n_pass++;
        wr_reg(A_CTL, 32'h1);
        n_total++; if (overrun !== 1'b0 || run !== 1'b1)
            $display("FAIL ovr_clear: got ovr=%b run=%b want 0/1", overrun, run); else n_pass++;
    endtask

    task automatic test_len_zero;
        logic [31:0] d;
        do_reset;
        wr_reg(A_LEN, 32'd0);
        wr_reg(A_CTL, 32'h1);
        for (int i = 0; i < 5; i++) begin d = $urandom; put(d); samp_q.push_back(d); repeat (3) tick; end
        model_frames(0);
        wait_out(exp_q.size());
        n_total++; if (got_q.size() !== exp_q.size()) $display("FAIL len0_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL len0_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_random;
        int sent = 0;
        logic [31:0] d;
        do_reset;
        wr_reg(A_LEN, 32'd7);
        wr_reg(A_CTL, 32'h1);
        while (sent < 10003) begin
            dst_rdy_i = ($urandom_range(3) != 0);
            if ($urandom_range(2) == 0) begin
                d = $urandom; sample = d; strobe = 1'b1;
                samp_q.push_back(d); sent++;
            end else begin
                strobe = 1'b0;
            end
            tick;
        end
        strobe = 1'b0;
        dst_rdy_i = 1'b1;
        model_frames(7);
        wait_out(exp_q.size());
        n_total++; if (got_q.size() !== exp_q.size()) $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL rand_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_total++; if (stall_viol !== 0) $display("FAIL rand_stall_stable: got %0d violations want 0", stall_viol); else n_pass++;
        n_total++; if (overrun !== 1'b0) $display("FAIL rand_overrun: got %b want 0", overrun); else n_pass++;
    endtask

    task automatic test_seq_wrap;
        logic [31:0] d;
        do_reset;
        wr_reg(A_LEN, 32'd1);
        wr_reg(A_CTL, 32'h1);
        for (int i = 0; i < 4100; i++) begin d = $urandom; put(d); samp_q.push_back(d); repeat (3) tick; end
        model_frames(1);
        wait_out(exp_q.size());
        n_total++; if (got_q.size() !== exp_q.size()) $display("FAIL wrap_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL wrap_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        do_reset;
        wr_reg(A_LEN, 32'd4);
        wr_reg(A_CTL, 32'h1);
        dst_rdy_i = 1'b0;
        for (int i = 0; i < 3; i++) put($urandom);
        dst_rdy_i = 1'b1;
        tick; tick;
        dst_rdy_i = 1'b0;
        n_total++; if (src_rdy_o !== 1'b1 || debug[23:12] !== 12'd1)
            $display("FAIL mid_body: got rdy=%b seq=%0d want 1/1", src_rdy_o, debug[23:12]); else n_pass++;
        rst = 1'b1;
        tick;
        n_total++; if (src_rdy_o !== 1'b0 || run !== 1'b0)
            $display("FAIL mid_rst_out: got rdy=%b run=%b want 0/0", src_rdy_o, run); else n_pass++;
        n_total++; if (debug[23:12] !== 12'd0 || overrun !== 1'b0 || debug[28:24] !== 5'd0)
            $display("FAIL mid_rst_state: got seq=%0d ovr=%b cnt=%0d want 0/0/0", debug[23:12], overrun, debug[28:24]); else n_pass++;
        rst = 1'b0;
        dst_rdy_i = 1'b1;
        got_q.delete(); exp_q.delete(); samp_q.delete(); exp_seq = 0;
        wr_reg(A_LEN, 32'd2);
        wr_reg(A_CTL, 32'h1);
        for (int i = 0; i < 2; i++) begin d = $urandom; put(d); samp_q.push_back(d); tick; end
        model_frames(2);
        wait_out(exp_q.size());
        n_total++; if (got_q.size() !== exp_q.size()) $display("FAIL mid_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL mid_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_basic;
        test_run_stop;
        test_overrun;
        test_len_zero;
        test_random;
        test_seq_wrap;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
